gate_seq_checker: RTL and testbench

Self-test sequencer for the team's 2-input gate cells (or_gate and siblings). On a start request it drives the gate's A/B inputs through all four combinations in order 00, 01, 10, 11. After each vector it waits a programmable settle time, then samples Y into a 4-bit result vector. At the end it compares the result against an expected truth table and reports pass/fail. It replaces hand-timed `#10` stimulus with a synthesizable, cycle-exact controller that sits between a test harness and one gate instance.

---
 rtl/gate_seq_pkg.sv | 26 ++
 rtl/settle_timer.sv | 33 +++
 rtl/gate_seq_checker.sv | 119 +++++++++++
 tb/tb_gate_seq_checker.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/gate_seq_pkg.sv
// ============================================================================
// Module      : gate_seq_pkg
// Description : Shared types and truth-table constants for the gate self-test
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gate_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2
    } state_t;

    localparam int NUM_VECTORS = 4;

    // Expected Y per {A,B} input vector, bit index = {A,B}
    localparam logic [3:0] OR_TT  = 4'b1110;
    localparam logic [3:0] AND_TT = 4'b1000;
    localparam logic [3:0] XOR_TT = 4'b0110;

endpackage

`default_nettype wire

// File: rtl/settle_timer.sv
// ============================================================================
// Module      : settle_timer
// Description : 8-bit loadable down-counter; flags the last cycle of a count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module settle_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       en,
    input  logic [7:0] load_val,
    output logic       expire
);

    logic [7:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 8'd0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (en && (r_cnt != 8'd0)) begin
            r_cnt <= r_cnt - 8'd1;
        end
    end

    assign expire = en && (r_cnt == 8'd1);

endmodule

`default_nettype wire

// File: rtl/gate_seq_checker.sv
// ============================================================================
// Module      : gate_seq_checker
// Description : Walks a 2-input gate through 00,01,10,11, samples Y after a
//               settle time and compares the result with a truth table.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_seq_checker
    import gate_seq_pkg::*;
#(
    parameter int         SETTLE_CYCLES = 2,
    parameter logic [3:0] EXPECT        = OR_TT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       A,
    output logic       B,
    input  logic       Y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] result_vec,
    output logic [3:0] fail_vec
);

    localparam logic [7:0] c_settle   = 8'(SETTLE_CYCLES);
    localparam logic [1:0] c_last_idx = 2'(NUM_VECTORS - 1);

    state_t     r_state;
    logic [1:0] r_idx;
    logic [1:0] r_ab;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [3:0] r_result;
    logic [3:0] r_fail;

    logic       w_load;
    logic       w_expire;
    logic [3:0] w_final;

    // Timer reloads on the start edge and on every intermediate sample edge
    assign w_load  = ((r_state == IDLE) && start) ||
                     ((r_state == SAMPLE) && (r_idx != c_last_idx));
    assign w_final = {Y, r_result[2:0]};

    settle_timer u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_load),
        .en       (r_state == SETTLE),
        .load_val (c_settle),
        .expire   (w_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_idx    <= 2'd0;
            r_ab     <= 2'b00;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_result <= 4'd0;
            r_fail   <= 4'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_idx    <= 2'd0;
                        r_ab     <= 2'b00;
                        r_busy   <= 1'b1;
                        r_result <= 4'd0;
                        r_fail   <= 4'd0;
                        r_pass   <= 1'b0;
                        r_state  <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (w_expire) begin
                        r_state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    r_result[r_idx] <= Y;
                    if (r_idx != c_last_idx) begin
                        r_idx   <= r_idx + 2'd1;
                        r_ab    <= r_idx + 2'd1;
                        r_state <= SETTLE;
                    end else begin
                        r_pass  <= (w_final == EXPECT);
                        r_fail  <= w_final ^ EXPECT;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_ab    <= 2'b00;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign A          = r_ab[1];
    assign B          = r_ab[0];
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign result_vec = r_result;
    assign fail_vec   = r_fail;

endmodule

`default_nettype wire

// File: tb/tb_gate_seq_checker.sv
// ============================================================================
// Module      : tb_gate_seq_checker
// Description : Directed bench for gate_seq_checker with a run-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gate_seq_checker;
    import gate_seq_pkg::*;

    localparam int S0 = 2;
    localparam int S1 = 1;

    logic       clk;
    logic       rst_n;
    logic [1:0] start_v;
    logic [1:0] a_w, b_w, y_w, busy_w, done_w, pass_w;
    logic [3:0] res_w  [2];
    logic [3:0] fail_w [2];
    int         mode   [2];

    int n_vec = 0;
    int n_err = 0;
    int ecnt  = 0;
    int dn0   = 0;

    // 0 = OR gate, 1 = AND gate, 2 = output stuck at 0
    function automatic logic gate_y(int m, logic a, logic b);
        case (m)
            0:       return a | b;
            1:       return a & b;
            default: return 1'b0;
        endcase
    endfunction

    assign y_w[0] = gate_y(mode[0], a_w[0], b_w[0]);
    assign y_w[1] = gate_y(mode[1], a_w[1], b_w[1]);

    gate_seq_checker #(.SETTLE_CYCLES(S0), .EXPECT(OR_TT)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .A(a_w[0]), .B(b_w[0]),
        .Y(y_w[0]), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
        .result_vec(res_w[0]), .fail_vec(fail_w[0])
    );

    gate_seq_checker #(.SETTLE_CYCLES(S1), .EXPECT(AND_TT)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .A(a_w[1]), .B(b_w[1]),
        .Y(y_w[1]), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
        .result_vec(res_w[1]), .fail_vec(fail_w[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        ecnt <= ecnt + 1;
        if (done_w[0] === 1'b1) dn0 <= dn0 + 1;
    end

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at edge %0d", name, act, exp, ecnt);
        end
    endtask

    // Run-level model: k counts edges since the start edge; a run lasts
    // 4*(S+1) edges and Y for vector v is captured on edge (v+1)*(S+1).
    int         sv    [2] = '{S0, S1};
    logic [3:0] ev    [2] = '{OR_TT, AND_TT};
    bit         m_run [2] = '{1'b0, 1'b0};
    int         m_k   [2] = '{0, 0};
    bit         m_done[2] = '{1'b0, 1'b0};
    bit         m_pass[2] = '{1'b0, 1'b0};
    logic [3:0] m_res [2] = '{4'd0, 4'd0};
    logic [3:0] m_fail[2] = '{4'd0, 4'd0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_run[i] = 0; m_k[i] = 0; m_done[i] = 0; m_pass[i] = 0;
                m_res[i] = 4'd0; m_fail[i] = 4'd0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_done[i] = 0;
                if (m_run[i]) begin
                    int v;
                    m_k[i]++;
                    if (m_k[i] % (sv[i] + 1) == 0) begin
                        v = m_k[i] / (sv[i] + 1) - 1;
                        m_res[i][v] = gate_y(mode[i], v[1], v[0]);
                    end
                    if (m_k[i] == 4 * (sv[i] + 1)) begin
                        m_run[i]  = 0;
                        m_done[i] = 1;
                        m_pass[i] = (m_res[i] == ev[i]);
                        m_fail[i] = m_res[i] ^ ev[i];
                    end
                end else if (start_v[i]) begin
                    m_run[i]  = 1;
                    m_k[i]    = 0;
                    m_res[i]  = 4'd0;
                    m_pass[i] = 0;
                    m_fail[i] = 4'd0;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic [1:0] eab;
            eab = m_run[i] ? 2'(m_k[i] / (sv[i] + 1)) : 2'b00;
            check($sformatf("dut%0d busy/done/ab/res/pass/fail", i),
                  {3'b0, busy_w[i], done_w[i], a_w[i], b_w[i], res_w[i], pass_w[i], fail_w[i]},
                  {3'b0, m_run[i], m_done[i], eab, m_res[i], m_pass[i], m_fail[i]});
        end
    end

    task automatic pulse(logic [1:0] which, output int e0);
        @(negedge clk);
        start_v = which;
        @(negedge clk);
        start_v = 2'b00;
        e0 = ecnt;
    endtask

    task automatic wait_done(int i, int bound, output int e);
        e = -1;
        for (int c = 0; c < bound; c++) begin
            @(negedge clk);
            if (done_w[i] === 1'b1) begin
                e = ecnt;
                return;
            end
        end
        n_vec++;
        n_err++;
        $display("FAIL dut%0d done timeout: got none expected pulse within %0d", i, bound);
    endtask

    initial begin
        int e0, e1, e2, snap;
        mode[0] = 0;
        mode[1] = 1;
        start_v = 2'b00;
        rst_n   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset outputs", {busy_w[0], done_w[0], a_w[0], b_w[0], pass_w[0], res_w[0], fail_w[0]}, 16'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // OR gate, plus a stray start at edge 5 that must be ignored
        pulse(2'b01, e0);
        while (ecnt < e0 + 4) @(negedge clk);
        start_v = 2'b01;
        @(negedge clk);
        start_v = 2'b00;
        snap = dn0;
        wait_done(0, 30, e1);
        check("or done edge", 16'(e1 - e0), 16'd12);
        check("or result", {12'd0, res_w[0]}, 16'b1110);
        check("or pass/fail", {11'd0, pass_w[0], fail_w[0]}, {11'd0, 1'b1, 4'b0000});
        repeat (20) @(negedge clk);
        check("or single done", 16'(dn0 - snap), 16'd1);

        // Stuck-at-0 output
        mode[0] = 2;
        pulse(2'b01, e0);
        wait_done(0, 30, e1);
        check("y0 done edge", 16'(e1 - e0), 16'd12);
        check("y0 result/fail/pass", {7'd0, res_w[0], fail_w[0], pass_w[0]}, {7'd0, 4'b0000, 4'b1110, 1'b0});
        mode[0] = 0;
        repeat (3) @(negedge clk);

        // AND gate with a single settle cycle
        pulse(2'b10, e0);
        wait_done(1, 30, e1);
        check("and done edge", 16'(e1 - e0), 16'd8);
        check("and result/pass", {11'd0, res_w[1], pass_w[1]}, {11'd0, 4'b1000, 1'b1});
        repeat (3) @(negedge clk);

        // Asynchronous reset mid-run, just after edge 7
        pulse(2'b01, e0);
        while (ecnt < e0 + 6) @(negedge clk);
        @(posedge clk);
        #1;
        check("pre-reset ab", {14'd0, a_w[0], b_w[0]}, 16'b10);
        snap = dn0;
        rst_n = 1'b0;
        #1;
        check("abort outputs", {9'd0, a_w[0], b_w[0], busy_w[0], res_w[0]}, 16'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check("no done after abort", 16'(dn0 - snap), 16'd0);
        pulse(2'b01, e0);
        wait_done(0, 30, e1);
        check("rerun done edge", 16'(e1 - e0), 16'd12);
        check("rerun pass", {15'd0, pass_w[0]}, 16'd1);
        repeat (3) @(negedge clk);

        // start held high: back-to-back runs with one IDLE cycle between
        @(negedge clk);
        start_v = 2'b01;
        @(negedge clk);
        e0 = ecnt;
        wait_done(0, 30, e1);
        check("b2b first done", 16'(e1 - e0), 16'd12);
        check("b2b first pass", {15'd0, pass_w[0]}, 16'd1);
        check("b2b idle gap", {15'd0, busy_w[0]}, 16'd0);
        @(negedge clk);
        check("b2b restart busy", {15'd0, busy_w[0]}, 16'd1);
        wait_done(0, 30, e2);
        check("b2b second done", 16'(e2 - e0), 16'd25);
        check("b2b second pass", {15'd0, pass_w[0]}, 16'd1);
        start_v = 2'b00;
        repeat (20) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
